// File: rtl/mips8_pkg.sv
// Shared types and constants for the MIPS8 core front end.
package mips8_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with a hold / +1 / redirect next-pc mux.
module pc_unit
  import mips8_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter logic [AW-1:0] RST_PC = RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_next_pc;

  // Redirect outranks increment; wrap-around of +1 is intentional.
  always_comb begin
    w_next_pc = r_pc;
    if (i_redirect) begin
      w_next_pc = i_redirect_pc;
    end else if (i_inc) begin
      w_next_pc = r_pc + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RST_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: BOOT/RUN/HALT control, IF/ID register and
// saturating fetched-instruction counter around the pc_unit.
module fetch_stage
  import mips8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count,
  output fetch_state_t       dbg_state
);

  // if_id_valid qualifies the IF/ID word: 1 = real instruction, 0 = bubble.
  // There is no back-pressure handshake; stall simply freezes the register.

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [ADDR_W-1:0]  w_pc;
  logic               w_issue;
  logic               w_flush;
  logic               w_pc_inc;
  logic               w_pc_redirect;

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_q;
  logic [ADDR_W-1:0]  r_pc_plus1;
  logic               r_valid;
  logic [CNT_W-1:0]   r_count;

  pc_unit #(
    .AW     (ADDR_W),
    .RST_PC (RESET_PC)
  ) u_pc_unit (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_pc_inc),
    .i_redirect    (w_pc_redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_issue       = 1'b0;
    w_flush       = 1'b0;
    w_pc_inc      = 1'b0;
    w_pc_redirect = 1'b0;
    case (r_state)
      BOOT: w_next_state = RUN;
      RUN: begin
        if (halt_req) begin
          w_next_state = HALT;
          w_flush      = 1'b1;
        end else if (redirect_valid) begin
          w_pc_redirect = 1'b1;
          w_flush       = 1'b1;
        end else if (!stall) begin
          w_issue  = 1'b1;
          w_pc_inc = 1'b1;
        end
      end
      HALT: w_next_state = HALT;
      default: w_next_state = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_q     <= '0;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (w_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (w_issue) begin
      r_instr    <= imem_data;
      r_pc_q     <= w_pc;
      r_pc_plus1 <= w_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      r_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_issue && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign imem_addr      = w_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc       = r_pc_q;
  assign if_id_pc_plus1 = r_pc_plus1;
  assign if_id_valid    = r_valid;
  assign halted         = (r_state == HALT);
  assign fetch_count    = r_count;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational ROM model.
module tb_fetch_stage;
  import mips8_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt_req;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic [ADDR_W-1:0]  if_id_pc_plus1;
  logic               if_id_valid;
  logic               halted;
  logic [15:0]        fetch_count;
  fetch_state_t       dbg_state;

  int n_checks;
  int n_fails;

  fetch_stage #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model
  always_comb begin
    case (imem_addr)
      8'h00:   imem_data = 16'h4A0A;
      8'h01:   imem_data = 16'h4E02;
      8'h02:   imem_data = 16'h4800;
      8'h03:   imem_data = 16'h1111;
      8'h04:   imem_data = 16'h2222;
      8'h05:   imem_data = 16'h3333;
      8'h0D:   imem_data = 16'h3700;
      8'h0E:   imem_data = 16'h3701;
      8'h12:   imem_data = 16'h0D80;
      8'h13:   imem_data = 16'h0D81;
      8'h14:   imem_data = 16'h0D82;
      8'h15:   imem_data = 16'h0D83;
      default: imem_data = 16'h0000;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; halt_req = 1'b0;
    #12;
    n_checks++;
    if (imem_addr !== 8'h00 || if_id_instr !== 16'h0000 || if_id_valid !== 1'b0 ||
        halted !== 1'b0 || fetch_count !== 16'h0000 || if_id_pc !== 8'h00 ||
        if_id_pc_plus1 !== 8'h00 || dbg_state !== BOOT) begin
      n_fails++;
      $display("FAIL reset: addr=%h instr=%h v=%b h=%b cnt=%h pc=%h pc1=%h st=%0d, required 00 0000 0 0 0000 00 00 0",
               imem_addr, if_id_instr, if_id_valid, halted, fetch_count, if_id_pc, if_id_pc_plus1, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    step();
    n_checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 8'h00 || dbg_state !== RUN) begin
      n_fails++;
      $display("FAIL boot_bubble: v=%b addr=%h st=%0d, required 0 00 1", if_id_valid, imem_addr, dbg_state);
    end
    step();
    n_checks++;
    if (if_id_instr !== 16'h4A0A || if_id_pc !== 8'h00 || if_id_pc_plus1 !== 8'h01 || if_id_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL fetch0: instr=%h pc=%h pc1=%h v=%b, required 4A0A 00 01 1", if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid);
    end
    step();
    n_checks++;
    if (if_id_instr !== 16'h4E02 || if_id_pc !== 8'h01 || imem_addr !== 8'h02 || fetch_count !== 16'd2) begin
      n_fails++;
      $display("FAIL fetch1: instr=%h pc=%h addr=%h cnt=%h, required 4E02 01 02 0002", if_id_instr, if_id_pc, imem_addr, fetch_count);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (if_id_instr !== 16'h4E02 || if_id_pc !== 8'h01 || imem_addr !== 8'h02 ||
          fetch_count !== 16'd2 || if_id_valid !== 1'b1) begin
        n_fails++;
        $display("FAIL stall_hold[%0d]: instr=%h pc=%h addr=%h cnt=%h v=%b, required 4E02 01 02 0002 1",
                 i, if_id_instr, if_id_pc, imem_addr, fetch_count, if_id_valid);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if (if_id_instr !== 16'h4800 || if_id_pc !== 8'h02 || fetch_count !== 16'd3) begin
      n_fails++;
      $display("FAIL stall_release: instr=%h pc=%h cnt=%h, required 4800 02 0003", if_id_instr, if_id_pc, fetch_count);
    end
    step();
    step();
    n_checks++;
    if (if_id_instr !== 16'h2222 || if_id_pc !== 8'h04 || imem_addr !== 8'h05 || fetch_count !== 16'd5) begin
      n_fails++;
      $display("FAIL run_to_05: instr=%h pc=%h addr=%h cnt=%h, required 2222 04 05 0005", if_id_instr, if_id_pc, imem_addr, fetch_count);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 8'h0D;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 || imem_addr !== 8'h0D || fetch_count !== 16'd5) begin
      n_fails++;
      $display("FAIL redirect_flush: v=%b instr=%h addr=%h cnt=%h, required 0 0000 0D 0005", if_id_valid, if_id_instr, imem_addr, fetch_count);
    end
    step();
    n_checks++;
    if (if_id_instr !== 16'h3700 || if_id_pc !== 8'h0D || if_id_pc_plus1 !== 8'h0E ||
        if_id_valid !== 1'b1 || fetch_count !== 16'd6) begin
      n_fails++;
      $display("FAIL redirect_target: instr=%h pc=%h pc1=%h v=%b cnt=%h, required 3700 0D 0E 1 0006",
               if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, fetch_count);
    end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h12;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 8'h12) begin
      n_fails++;
      $display("FAIL stall_redirect_flush: v=%b addr=%h, required 0 12", if_id_valid, imem_addr);
    end
    step();
    n_checks++;
    if (if_id_instr !== 16'h0D80 || if_id_pc !== 8'h12 || if_id_valid !== 1'b1 || fetch_count !== 16'd7) begin
      n_fails++;
      $display("FAIL stall_redirect_target: instr=%h pc=%h v=%b cnt=%h, required 0D80 12 1 0007",
               if_id_instr, if_id_pc, if_id_valid, fetch_count);
    end
  endtask

  task automatic test_halt();
    step();
    step();
    n_checks++;
    if (imem_addr !== 8'h15 || fetch_count !== 16'd9) begin
      n_fails++;
      $display("FAIL pre_halt: addr=%h cnt=%h, required 15 0009", imem_addr, fetch_count);
    end
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n_checks++;
    if (halted !== 1'b1 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 ||
        imem_addr !== 8'h15 || dbg_state !== HALT) begin
      n_fails++;
      $display("FAIL halt_enter: h=%b v=%b instr=%h addr=%h st=%0d, required 1 0 0000 15 2",
               halted, if_id_valid, if_id_instr, imem_addr, dbg_state);
    end
    for (int i = 0; i < 4; i++) begin
      redirect_valid = i[0]; redirect_pc = 8'h40; stall = ~i[0]; halt_req = i[1];
      step();
      n_checks++;
      if (halted !== 1'b1 || if_id_valid !== 1'b0 || imem_addr !== 8'h15 || fetch_count !== 16'd9) begin
        n_fails++;
        $display("FAIL halt_sticky[%0d]: h=%b v=%b addr=%h cnt=%h, required 1 0 15 0009",
                 i, halted, if_id_valid, imem_addr, fetch_count);
      end
    end
    redirect_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (halted !== 1'b0 || imem_addr !== 8'h00 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000 ||
        if_id_pc !== 8'h00 || if_id_pc_plus1 !== 8'h00 || fetch_count !== 16'h0000 || dbg_state !== BOOT) begin
      n_fails++;
      $display("FAIL async_reset: h=%b addr=%h v=%b instr=%h pc=%h pc1=%h cnt=%h st=%0d, required 0 00 0 0000 00 00 0000 0",
               halted, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1, fetch_count, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (if_id_instr !== 16'h4A0A || if_id_pc !== 8'h00 || if_id_valid !== 1'b1 || fetch_count !== 16'd1) begin
      n_fails++;
      $display("FAIL restart: instr=%h pc=%h v=%b cnt=%h, required 4A0A 00 1 0001", if_id_instr, if_id_pc, if_id_valid, fetch_count);
    end
  endtask

  task automatic test_wrap_saturate();
    logic [7:0]  exp_pc [4];
    logic [7:0]  exp_pc1 [4];
    logic [15:0] exp_ins [4];
    logic [15:0] exp_cnt;
    exp_pc  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_pc1 = '{8'hFF, 8'h00, 8'h01, 8'h02};
    exp_ins = '{16'h0000, 16'h0000, 16'h4A0A, 16'h4E02};
    exp_cnt = 16'd1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (if_id_pc !== exp_pc[i] || if_id_pc_plus1 !== exp_pc1[i] || if_id_instr !== exp_ins[i] ||
          if_id_valid !== 1'b1 || fetch_count !== exp_cnt) begin
        n_fails++;
        $display("FAIL wrap[%0d]: pc=%h pc1=%h instr=%h v=%b cnt=%h, required %h %h %h 1 %h",
                 i, if_id_pc, if_id_pc_plus1, if_id_instr, if_id_valid, fetch_count,
                 exp_pc[i], exp_pc1[i], exp_ins[i], exp_cnt);
      end
    end
    for (int i = 0; i < 65540; i++) begin
      step();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    n_checks++;
    if (fetch_count !== 16'hFFFF || fetch_count !== exp_cnt || imem_addr !== 8'h06 || if_id_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL saturate: cnt=%h addr=%h v=%b, required FFFF 06 1", fetch_count, imem_addr, if_id_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_halt();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
